gf_muls_4_dom_pipe: RTL

//  LANES-wide, domain-oriented-masked (DOM-indep, 2 shares) GF(2^4)/GF(2^2) multiplier,

---
 rtl/gf_muls_4_dom_pipe.sv | 136 +++++++++++++
 1 files changed

// File: rtl/gf_muls_4_dom_pipe.sv
// ============================================================================
//  Module      : gf_muls_4_dom_pipe
//  Description : LANES-wide two-share DOM-indep GF(2^4) multiplier in the
//                normal basis [alpha^8, alpha^2]. Cross-domain partial
//                products are refreshed with z and registered before they
//                are compressed. Optional output register. Global-stall
//                valid/ready flow control.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gf_muls_4_dom_pipe #(
    parameter int LANES   = 1,
    parameter int OUT_REG = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*LANES-1:0]   a0,
    input  logic [4*LANES-1:0]   a1,
    input  logic [4*LANES-1:0]   b0,
    input  logic [4*LANES-1:0]   b1,
    input  logic [4*LANES-1:0]   z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*LANES-1:0]   q0,
    output logic [4*LANES-1:0]   q1
);

    localparam int c_width = 4 * LANES;

    // GF(2^2) multiply in normal basis
    function automatic logic [1:0] f_mul2(input logic [1:0] x, input logic [1:0] y);
        logic s;
        s = (x[1] ^ x[0]) & (y[1] ^ y[0]);
        return {(x[1] & y[1]) ^ s, (x[0] & y[0]) ^ s};
    endfunction

    // GF(2^2) multiply fused with the scaling by the GF(2^4) constant
    function automatic logic [1:0] f_scl2(input logic [1:0] x, input logic [1:0] y);
        logic t;
        t = x[0] & y[0];
        return {((x[1] ^ x[0]) & (y[1] ^ y[0])) ^ t, (x[1] & y[1]) ^ t};
    endfunction

    // GF(2^4) multiply built from the GF(2^2) tower
    function automatic logic [3:0] f_mul4(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] p;
        p = f_scl2(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]);
        return {f_mul2(a[3:2], b[3:2]) ^ p, f_mul2(a[1:0], b[1:0]) ^ p};
    endfunction

    logic               w_en;
    logic [c_width-1:0] w_t00;
    logic [c_width-1:0] w_t01;
    logic [c_width-1:0] w_t10;
    logic [c_width-1:0] w_t11;
    logic [c_width-1:0] r_t00;
    logic [c_width-1:0] r_t01;
    logic [c_width-1:0] r_t10;
    logic [c_width-1:0] r_t11;
    logic               r_v1;
    logic [c_width-1:0] w_c0;
    logic [c_width-1:0] w_c1;

    // Global stall: the whole pipe advances only when the output slot frees up.
    // in_ready depends on state and out_ready only, never on in_valid.
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    // Per-lane partial products; cross terms are refreshed with the same z so
    // that z cancels in q0^q1.
    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            assign w_t00[4*i +: 4] = f_mul4(a0[4*i +: 4], b0[4*i +: 4]);
            assign w_t11[4*i +: 4] = f_mul4(a1[4*i +: 4], b1[4*i +: 4]);
            assign w_t01[4*i +: 4] = f_mul4(a0[4*i +: 4], b1[4*i +: 4]) ^ z[4*i +: 4];
            assign w_t10[4*i +: 4] = f_mul4(a1[4*i +: 4], b0[4*i +: 4]) ^ z[4*i +: 4];
        end
    endgenerate

    // Stage 1: register all four terms before any cross-domain compression
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1  <= 1'b0;
            r_t00 <= '0;
            r_t01 <= '0;
            r_t10 <= '0;
            r_t11 <= '0;
        end else if (w_en) begin
            r_v1  <= in_valid;
            r_t00 <= w_t00;
            r_t01 <= w_t01;
            r_t10 <= w_t10;
            r_t11 <= w_t11;
        end
    end

    // Compression: each output share only touches its own domain plus a
    // registered refreshed cross term.
    assign w_c0 = r_t00 ^ r_t01;
    assign w_c1 = r_t11 ^ r_t10;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic               r_v2;
            logic [c_width-1:0] r_q0;
            logic [c_width-1:0] r_q1;

            // Stage 2: optional output register, stalls together with stage 1
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v2 <= 1'b0;
                    r_q0 <= '0;
                    r_q1 <= '0;
                end else if (w_en) begin
                    r_v2 <= r_v1;
                    r_q0 <= w_c0;
                    r_q1 <= w_c1;
                end
            end

            assign out_valid = r_v2;
            assign q0        = r_q0;
            assign q1        = r_q1;
        end else begin : g_out_comb
            assign out_valid = r_v1;
            assign q0        = w_c0;
            assign q1        = w_c1;
        end
    endgenerate

endmodule

`default_nettype wire
